// File: rtl/sobel_window_scheduler.sv
`timescale 1ns/1ps
// sobel_window_scheduler
// Accepts a raster-order 8-bit pixel stream for one frame and presents a
// registered 3x3 neighbourhood for every interior pixel, together with the
// centre coordinates, to the gradient stage. Two line buffers hold the
// previous rows; a pair of column registers holds the previous two columns.
module sobel_window_scheduler #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_pixel,
    output logic          in_ready,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [71:0]   win_pixels,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);

    state_t        state;
    logic [CW-1:0] row;
    logic [CW-1:0] col;

    // lb1 holds row r-2, lb0 holds row r-1 at the column being written
    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];

    // Column packing: [7:0] top, [15:8] middle, [23:16] bottom.
    // col1_p0 is the previous column, col2_p0 the one before it.
    logic [23:0]   col1_p0;
    logic [23:0]   col2_p0;
    logic [23:0]   new_col;

    logic          accept;
    logic          out_xfer;
    logic          emit;

    // Assemble a row-major window from three columns, top-left in the LSB
    function automatic logic [71:0] pack_window(input logic [23:0] left,
                                                input logic [23:0] middle,
                                                input logic [23:0] right);
        return {right[23:16], middle[23:16], left[23:16],
                right[15:8],  middle[15:8],  left[15:8],
                right[7:0],   middle[7:0],   left[7:0]};
    endfunction

    assign in_ready = (state == RUN) && (!win_valid || win_ready);
    assign accept   = in_valid && in_ready;
    assign out_xfer = win_valid && win_ready;
    assign busy     = (state != IDLE);
    assign new_col  = {in_pixel, lb0[col], lb1[col]};
    // Only interior centres: the newest pixel must be at least two rows and
    // two columns in, which also guarantees no stale column from the
    // previous row is ever part of an emitted window.
    assign emit     = (row >= CW'(2)) && (col >= CW'(2));

    // Line buffers and column shift registers: pure data, left unreset
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= in_pixel;
            col2_p0  <= col1_p0;
            col1_p0  <= new_col;
        end
    end

    // Frame FSM, raster counters and the registered window output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            win_valid  <= 1'b0;
            win_pixels <= '0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_xfer) begin
                win_valid <= 1'b0;
            end
            // A fresh window overrides the clear when both happen together
            if (accept && emit) begin
                win_valid  <= 1'b1;
                win_pixels <= pack_window(col2_p0, col1_p0, new_col);
                win_row    <= row - CW'(1);
                win_col    <= col - CW'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        row   <= '0;
                        col   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + CW'(1);
                            if (row == LAST_ROW) begin
                                state <= DRAIN;
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!win_valid || out_xfer) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
